perceptron_scheduler: RTL and testbench

Time-multiplexed controller that evaluates 8 perceptrons with one shared adder/comparator instead of 8 parallel datapaths. It holds a register-file of per-neuron weights, bias and threshold, loadable at runtime over a byte-wide config port. On a start pulse it sequences every neuron over every input bit and publishes an 8-bit fire vector. It sits between the top-level pins and the output driver, replacing hard-wired weights with programmable ones.

---
 rtl/perceptron_scheduler.sv | 153 +++++++++++++++
 tb/tb_perceptron_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_scheduler.sv
// Time-multiplexed evaluator for a bank of binary-input perceptrons.
// One saturating adder and one comparator are shared across all neurons and inputs.
module perceptron_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int N_INPUTS  = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_INPUTS-1:0]  x_in,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_neuron,
  input  logic [3:0]           cfg_sel,
  input  logic [W_WIDTH-1:0]   cfg_data,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [N_NEURONS-1:0] result
);

  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [NW-1:0] LAST_NEURON = NW'(N_NEURONS - 1);
  localparam logic [IW-1:0] LAST_INPUT  = IW'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ACCUM,
    S_CMP,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [W_WIDTH-1:0]   weight    [N_NEURONS][N_INPUTS];
  logic [W_WIDTH-1:0]   bias      [N_NEURONS];
  logic [W_WIDTH-1:0]   threshold [N_NEURONS];

  logic [N_INPUTS-1:0]  x_reg;
  logic [NW-1:0]        neuron;
  logic [IW-1:0]        idx;
  logic [ACC_WIDTH-1:0] acc;
  logic [N_NEURONS-1:0] shadow;

  logic                 cfg_ok;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] sum_sat;
  logic                 fire;

  assign cfg_ok = cfg_we && !busy;

  // Extra carry bit detects overflow so the accumulator clamps instead of wrapping.
  always_comb begin
    sum_wide = {1'b0, acc} + (ACC_WIDTH+1)'(weight[neuron][idx]);
    sum_sat  = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
    fire     = (acc >= ACC_WIDTH'(threshold[neuron]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_INIT;
      S_INIT:  state_next = S_ACCUM;
      S_ACCUM: if (idx == LAST_INPUT) state_next = S_CMP;
      S_CMP:   state_next = (neuron == LAST_NEURON) ? S_DONE : S_INIT;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Config register file; writes only land while no run is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        for (int i = 0; i < N_INPUTS; i++) begin
          weight[n][i] <= '0;
        end
        bias[n]      <= '0;
        threshold[n] <= W_WIDTH'(2);
      end
    end else if (cfg_ok) begin
      if (int'(cfg_sel) < N_INPUTS) begin
        weight[cfg_neuron][cfg_sel[IW-1:0]] <= cfg_data;
      end else if (cfg_sel == 4'd8) begin
        bias[cfg_neuron] <= cfg_data;
      end else if (cfg_sel == 4'd9) begin
        threshold[cfg_neuron] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      result  <= '0;
      x_reg   <= '0;
      neuron  <= '0;
      idx     <= '0;
      acc     <= '0;
      shadow  <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= cfg_we && busy;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_reg  <= x_in;
            neuron <= '0;
            busy   <= 1'b1;
          end
        end
        S_INIT: begin
          acc <= ACC_WIDTH'(bias[neuron]);
          idx <= '0;
        end
        S_ACCUM: begin
          if (x_reg[idx]) begin
            acc <= sum_sat;
          end
          idx <= idx + 1'b1;
        end
        S_CMP: begin
          shadow[neuron] <= fire;
          if (neuron != LAST_NEURON) begin
            neuron <= neuron + 1'b1;
          end
        end
        // The shadow vector keeps partial results off the visible output.
        S_DONE: begin
          result <= shadow;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_scheduler.sv
// Scoreboard bench for perceptron_scheduler: a 16-bit and an 8-bit accumulator
// build share the same stimulus, expected fire vectors come from a behavioural model.
module tb_perceptron_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_in = 8'h00;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_neuron = 3'd0;
  logic [3:0] cfg_sel = 4'd0;
  logic [7:0] cfg_data = 8'h00;

  logic       busy, done, cfg_err;
  logic [7:0] result;
  logic       busy8, done8, cfg_err8;
  logic [7:0] result8;

  int checks_total = 0;
  int checks_passed = 0;

  logic [7:0] m_w [8][8];
  logic [7:0] m_b [8];
  logic [7:0] m_t [8];
  logic [7:0] sb16 [$];
  logic [7:0] sb8  [$];
  logic [7:0] last_expected = 8'h00;

  always #5 clk = ~clk;

  perceptron_scheduler #(.N_NEURONS(8), .N_INPUTS(8), .W_WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .busy(busy), .done(done), .cfg_err(cfg_err), .result(result)
  );

  perceptron_scheduler #(.N_NEURONS(8), .N_INPUTS(8), .W_WIDTH(8), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .busy(busy8), .done(done8), .cfg_err(cfg_err8), .result(result8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [7:0] modelResult(input logic [7:0] x, input int accw);
    logic [7:0] r;
    longint acc;
    longint maxv;
    r = 8'h00;
    maxv = (longint'(1) << accw) - 1;
    for (int n = 0; n < 8; n++) begin
      acc = longint'(m_b[n]);
      for (int i = 0; i < 8; i++) begin
        if (x[i]) acc = acc + longint'(m_w[n][i]);
      end
      if (acc > maxv) acc = maxv;
      r[n] = (acc >= longint'(m_t[n]));
    end
    return r;
  endfunction

  task automatic modelDefaults();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) m_w[n][i] = 8'd0;
      m_b[n] = 8'd0;
      m_t[n] = 8'd2;
    end
    sb16.delete();
    sb8.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_result", result, 0);
    checkOutput("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelDefaults();
  endtask

  task automatic cfgWrite(input int n, input int sel, input logic [7:0] data);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_neuron = 3'(n);
    cfg_sel = 4'(sel);
    cfg_data = data;
    if (sel < 8) m_w[n][sel] = data;
    else if (sel == 8) m_b[n] = data;
    else if (sel == 9) m_t[n] = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] x, input bit hold);
    @(negedge clk);
    start = 1'b1;
    x_in = x;
    sb16.push_back(modelResult(x, 16));
    sb8.push_back(modelResult(x, 8));
    @(negedge clk);
    if (!hold) start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic popCompare();
    logic [7:0] e16, e8;
    if (sb16.size() == 0 || sb8.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      e16 = sb16.pop_front();
      e8 = sb8.pop_front();
      last_expected = e16;
      checkOutput("result", result, e16);
      checkOutput("result_acc8", result8, e8);
      checkOutput("done_acc8", done8, 1);
    end
  endtask

  task automatic waitDone(input int err_k, input int restart_k, input bit toggle);
    int k_done;
    k_done = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (err_k > 0 && k == err_k) begin
        checkOutput("cfg_err_pulse", cfg_err, 1);
        cfg_we = 1'b0;
      end
      if (restart_k > 0 && k == restart_k) start = 1'b0;
      if (k == 80) checkOutput("busy_E80", busy, 1);
      if (done) begin
        k_done = k;
        break;
      end
      if (err_k > 0 && k == err_k - 1) begin
        cfg_we = 1'b1;
        cfg_neuron = 3'd3;
        cfg_sel = 4'd9;
        cfg_data = 8'd200;
      end
      if (restart_k > 0 && k == restart_k - 1) begin
        start = 1'b1;
        x_in = 8'hFF;
      end
      if (toggle) x_in = 8'($urandom);
    end
    if (k_done < 0) begin
      checkOutput("done_timeout", 0, 1);
    end else begin
      checkOutput("done_latency", k_done, 81);
      checkOutput("busy_at_done", busy, 0);
      popCompare();
      @(negedge clk);
      checkOutput("done_single_cycle", done, 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int done_count;
    int done_ks [$];

    modelDefaults();
    repeat (2) @(negedge clk);
    checkOutput("por_result", result, 0);
    checkOutput("por_busy", busy, 0);
    checkOutput("por_done", done, 0);
    checkOutput("por_cfg_err", cfg_err, 0);
    rst_n = 1'b1;

    $display("[TB] reset defaults run");
    applyStimulus(8'h00, 0);
    waitDone(-1, -1, 0);
    applyStimulus(8'hFF, 0);
    waitDone(-1, -1, 0);

    $display("[TB] single neuron program");
    begin
      logic [7:0] w0 [8];
      w0 = '{8'd2, 8'd4, 8'd2, 8'd1, 8'd5, 8'd2, 8'd2, 8'd2};
      for (int i = 0; i < 8; i++) cfgWrite(0, i, w0[i]);
    end
    cfgWrite(0, 8, 8'd0);
    cfgWrite(0, 9, 8'd2);
    cfgWrite(5, 12, 8'd77);
    checkOutput("ignored_sel_no_err", cfg_err, 0);
    applyStimulus(8'h08, 0);
    waitDone(-1, -1, 0);
    checkOutput("n0_below", result[0], 0);
    applyStimulus(8'h01, 0);
    waitDone(-1, -1, 0);
    checkOutput("n0_equal_fires", result[0], 1);
    applyStimulus(8'h10, 0);
    waitDone(-1, -1, 0);

    $display("[TB] all neurons full input");
    for (int n = 0; n < 8; n++) begin
      for (int s = 0; s < 10; s++) cfgWrite(n, s, 8'd255);
    end
    applyStimulus(8'hFF, 0);
    waitDone(-1, -1, 0);
    checkOutput("full_all_fire", result, 8'hFF);
    checkOutput("acc8_saturates", result8, 8'hFF);

    $display("[TB] busy rejection");
    doReset();
    cfgWrite(3, 8, 8'd150);
    applyStimulus(8'h00, 0);
    waitDone(10, 20, 0);
    done_count = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("no_second_done", done_count, 0);
    checkOutput("idle_after_ignored_start", busy, 0);

    $display("[TB] back to back with x toggling");
    cfgWrite(1, 0, 8'd3);
    cfgWrite(1, 5, 8'd9);
    cfgWrite(1, 9, 8'd10);
    applyStimulus(8'h21, 1);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k < 70) x_in = 8'($urandom);
      if (k == 70) begin
        x_in = 8'hF0;
        sb16.push_back(modelResult(8'hF0, 16));
        sb8.push_back(modelResult(8'hF0, 8));
      end
      if (done) begin
        done_ks.push_back(k);
        popCompare();
        if (done_ks.size() == 2) begin
          start = 1'b0;
          break;
        end
      end
    end
    if (done_ks.size() == 2) begin
      checkOutput("b2b_first_done", done_ks[0], 81);
      checkOutput("b2b_second_done", done_ks[1], 163);
    end else begin
      checkOutput("b2b_done_count", done_ks.size(), 2);
    end
    repeat (20) @(negedge clk);
    checkOutput("b2b_idle_after", busy, 0);

    $display("[TB] reset mid run");
    checkOutput("result_before_reset", result, last_expected);
    applyStimulus(8'hFF, 0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_result", result, 0);
    checkOutput("midrst_done", done, 0);
    modelDefaults();
    @(negedge clk);
    rst_n = 1'b1;
    done_count = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done || busy) done_count++;
    end
    checkOutput("midrst_no_activity", done_count, 0);
    applyStimulus(8'h00, 0);
    waitDone(-1, -1, 0);
    checkOutput("defaults_restored", result, 8'h00);
    applyStimulus(8'hFF, 0);
    waitDone(-1, -1, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
